// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
// Holds the FSM state encoding and the default widths and wait-state count.
package mem_stage_sram_ctrl_pkg;

    localparam int DEF_WORD_LEN        = 32;
    localparam int DEF_SRAM_ADDR_LEN   = 16;
    localparam int DEF_MEM_WAIT_CYCLES = 4;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'b00,
        MEM_ACCESS = 2'b01,
        MEM_DONE   = 2'b10
    } mem_state_e;

    function automatic int wait_cnt_width(input int wait_cycles);
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Wait-state up-counter for one SRAM transfer.
// Cleared on load, counts on enable, flags the final access cycle.
module mem_wait_counter
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_MEM_WAIT_CYCLES,
    parameter int CNT_W       = wait_cnt_width(WAIT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: runs a wait-stated SRAM read or write and freezes
// the upstream pipeline until the transfer completes.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int WORD_LEN      = DEF_WORD_LEN,
    parameter int SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
    parameter int WAIT_CYCLES   = DEF_MEM_WAIT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_r_en,
    input  logic                     mem_w_en,
    input  logic [WORD_LEN-1:0]      address,
    input  logic [WORD_LEN-1:0]      st_val,
    output logic [WORD_LEN-1:0]      read_data,
    output logic                     freeze,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [WORD_LEN-1:0]      sram_wdata,
    input  logic [WORD_LEN-1:0]      sram_rdata,
    output logic                     sram_we_n,
    output logic                     sram_oe_n
);

    mem_state_e state, state_next;
    logic       req, is_read;
    logic       cnt_load, cnt_en, cnt_tc, capture;
    logic       unused_addr;

    assign req     = mem_r_en | mem_w_en;
    assign is_read = mem_r_en & ~mem_w_en;

    mem_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A dropped request in ACCESS is a pipeline flush: abandon without capture.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        capture    = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (req) begin
                    state_next = MEM_ACCESS;
                    cnt_load   = 1'b1;
                end
            end
            MEM_ACCESS: begin
                if (!req) begin
                    state_next = MEM_IDLE;
                end else if (cnt_tc) begin
                    state_next = MEM_DONE;
                    capture    = is_read;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            MEM_DONE: state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (capture) begin
            read_data <= sram_rdata;
        end
    end

    assign freeze     = req & (state != MEM_DONE);
    assign ready      = (state == MEM_DONE);
    assign sram_addr  = address[SRAM_ADDR_LEN+1:2];
    assign sram_wdata = st_val;
    assign sram_we_n  = ~((state == MEM_ACCESS) & mem_w_en);
    assign sram_oe_n  = ~((state == MEM_ACCESS) & is_read);

    assign unused_addr = ^{address[WORD_LEN-1:SRAM_ADDR_LEN+2], address[1:0]};

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Sequences the MEM stage of the 5-stage pipeline against a multi-cycle external SRAM.
- Takes the registered EXE/MEM outputs (MEM_R_EN, MEM_W_EN, ALURes as address, STVal as store data) and runs a wait-stated SRAM read or write.
- Asserts freeze to the IF/ID, ID/EXE and EXE/MEM pipeline registers until the access completes.
- Returns load data to the MEM/WB path.

Parameters:
- WORD_LEN, 32, data/address word width (matches `WORD_LEN in defines.v).
- SRAM_ADDR_LEN, 16, SRAM word-address width.
- WAIT_CYCLES, 4, SRAM access cycles per transfer; legal range is 1 or greater.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request from EXE/MEM.
- mem_w_en  in  1  store request from EXE/MEM.
- address  in  WORD_LEN  byte address (EXE/MEM ALURes).
- st_val  in  WORD_LEN  store data (EXE/MEM STVal).
- read_data  out  WORD_LEN  registered load result to MEM/WB.
- freeze  out  1  hold all upstream pipeline registers and PC.
- ready  out  1  access completes this cycle.
- sram_addr  out  SRAM_ADDR_LEN  SRAM word address.
- sram_wdata  out  WORD_LEN  SRAM write data.
- sram_rdata  in  WORD_LEN  SRAM read data.
- sram_we_n  out  1  SRAM write enable, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.

Behaviour:
- Reset (rst=0, async):
  - state = IDLE, cnt = 0, read_data = 0.
  - sram_we_n = 1, sram_oe_n = 1.
  - freeze and ready are driven from the reset state as their combinational values.
  - A reset mid-access aborts it immediately; sram_we_n returns high without waiting for clk.
- req = mem_r_en | mem_w_en. If both are high, the access is a write; mem_r_en is ignored.
- States:
  - IDLE: if req, go to ACCESS and set cnt = 0. Otherwise stay in IDLE.
  - ACCESS, while req remains high:
    - If cnt == WAIT_CYCLES-1, go to DONE; for a read, capture sram_rdata into read_data on this edge.
    - Otherwise cnt = cnt+1.
  - ACCESS, if req drops (flush): go to IDLE. No capture, read_data is unchanged, no further SRAM strobes.
  - DONE: go to IDLE unconditionally. The pipeline advances on this edge, so any request seen next in IDLE belongs to a new instruction.
- Combinational outputs:
  - freeze = req & (state != DONE).
  - ready = (state == DONE).
  - sram_addr = address[SRAM_ADDR_LEN+1:2]. This is a word address; byte bits [1:0] are ignored.
  - sram_wdata = st_val.
  - sram_we_n = ~(state == ACCESS & mem_w_en).
  - sram_oe_n = ~(state == ACCESS & mem_r_en & ~mem_w_en).
- Latency:
  - freeze is high for exactly 1 + WAIT_CYCLES cycles: the IDLE cycle plus the ACCESS cycles.
  - ready is high for exactly 1 cycle, and freeze is low in that cycle.
  - For WAIT_CYCLES = 4: request visible at T0; freeze high T0–T4; ready at T5.
- Back-to-back accesses: each new access begins in IDLE on the cycle after DONE. There is no DONE-to-ACCESS shortcut.
- read_data holds its value until the next completed read. Writes and aborted accesses do not change it.
- With no request, freeze = 0 and the pipeline runs without stalls.
- Counter width is $clog2(WAIT_CYCLES+1). The counter never wraps, because the exit at WAIT_CYCLES-1 bounds it.

Decomposition:
- Add to defines.v:
  - state encodings `MEM_IDLE, `MEM_ACCESS, `MEM_DONE (2-bit).
  - `SRAM_ADDR_LEN.
  - `MEM_WAIT_CYCLES default.
- One sub-module, mem_wait_counter: loadable up-counter with async active-low clear and a terminal-count flag at WAIT_CYCLES-1.
- The FSM and output decode stay in mem_stage_sram_ctrl.

Test Plan:
- Load, WAIT_CYCLES=4: mem_r_en=1, address=0x0000_0410, sram_rdata=0xDEADBEEF → sram_addr=0x0104; sram_oe_n low during T1–T4; freeze=1 during T0–T4; ready=1 at T5; read_data=0xDEADBEEF from T5.
- Store: mem_w_en=1, address=0x8, st_val=0x12345678 → sram_addr=0x2; sram_wdata=0x12345678; sram_we_n low for exactly 4 cycles; read_data unchanged; ready at T5.
- Back-to-back: load then store → two freeze windows of 5 cycles each, separated by exactly one freeze-low (DONE) cycle; idle traffic (req=0) → freeze stays 0.
- Simultaneous mem_r_en=mem_w_en=1 → write performed, sram_oe_n stays 1, read_data unchanged; flush (req dropped) in ACCESS cnt=1 → state IDLE next cycle, no ready pulse, strobes deasserted.
- Async reset asserted mid-ACCESS, between clock edges → sram_we_n=1 and read_data=0 immediately; after release with req=0, state is IDLE and freeze=0.
- WAIT_CYCLES=1 build: load → freeze high for 2 cycles, ready on the 3rd, data captured correctly.
